// File: rtl/uart_tx_cfg_pkg.sv
// Shared constants and types for the configurable UART transmitter.
package uart_tx_cfg_pkg;

  // Clocks-per-bit divisors for a 12 MHz system clock
  localparam int unsigned B115200 = 104;
  localparam int unsigned B57600  = 208;
  localparam int unsigned B38400  = 313;
  localparam int unsigned B19200  = 625;
  localparam int unsigned B9600   = 1250;
  localparam int unsigned B4800   = 2500;
  localparam int unsigned B2400   = 5000;
  localparam int unsigned B1200   = 10000;
  localparam int unsigned B600    = 20000;
  localparam int unsigned B300    = 40000;

  // Parity modes
  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_t;

  // Clocks from accept edge to ready for one frame
  function automatic int unsigned frame_clocks(input int unsigned baud,
                                               input int unsigned dbits,
                                               input int unsigned par,
                                               input int unsigned sbits);
    return baud * (1 + dbits + ((par != PAR_NONE) ? 1 : 0) + sbits);
  endfunction

  // Counter width that never collapses to zero bits
  function automatic int unsigned width_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_baudgen_ena.sv
// Bit-period enable generator: one-cycle tick on the last clock of every bit period.
module baudgen_ena
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned BAUD = B115200
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = width_min1(BAUD);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Bit-period counter: restarts on clear, reloads explicitly at terminal count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == CW'(BAUD - 1))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Tick registered one count early so it is high during the last clock of the period
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= !clear && (r_cnt == CW'(BAUD - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with optional auto-repeat of the last latched byte.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned BAUD      = B115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PERIOD    = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_nxt;
  logic                 r_stop;
  logic                 w_stop_nxt;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_accept_ext;
  logic                 w_rep_due;

  // Bit timing, phase-aligned to every accept edge
  baudgen_ena #(
    .BAUD (BAUD)
  ) u_baudgen (
    .clk   (clk),
    .rstn  (rstn),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Parity of the byte latched by an external accept; repeats reuse it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par <= 1'b0;
    end else if (w_accept_ext) begin
      r_par <= (PARITY == PAR_ODD) ? ~^data : ^data;
    end
  end

  // Next-state, shift register rotation and next line value
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bit_nxt    = r_bit;
    w_stop_nxt   = r_stop;
    w_accept     = 1'b0;
    w_accept_ext = 1'b0;
    w_tx_nxt     = 1'b1;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_accept_ext = 1'b1;
          w_shift_nxt  = data;
          w_bit_nxt    = '0;
          w_stop_nxt   = 1'b0;
          w_state_nxt  = ST_START;
        end else if (w_rep_due) begin
          w_accept    = 1'b1;
          w_bit_nxt   = '0;
          w_stop_nxt  = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          // Rotate so the byte is intact again after the last bit, ready for a repeat
          w_shift_nxt = {r_shift[0], r_shift[DATA_BITS-1:1]};
          if (r_bit == BW'(DATA_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_stop_nxt  = 1'b0;
            w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      ST_PAR: begin
        if (w_tick) begin
          w_stop_nxt  = 1'b0;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_stop == 1'(STOP_BITS - 1)) begin
            w_stop_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_stop_nxt = r_stop + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      ST_PAR:   w_tx_nxt = r_par;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  if (PERIOD > 0) begin : g_rep
    localparam int unsigned FRAME = frame_clocks(BAUD, DATA_BITS, PARITY, STOP_BITS);
    localparam int unsigned P_EFF = (PERIOD < FRAME) ? FRAME : PERIOD;
    localparam int unsigned TW    = $clog2(P_EFF + 1);

    logic          r_armed;
    logic [TW-1:0] r_tmr;

    // Repeat timer: restarts at every accept, holds at terminal count until the repeat is taken
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_armed <= 1'b0;
        r_tmr   <= '0;
      end else if (w_accept) begin
        r_armed <= 1'b1;
        r_tmr   <= '0;
      end else if (r_armed && (r_tmr != TW'(P_EFF - 1))) begin
        r_tmr <= r_tmr + TW'(1);
      end
    end

    assign w_rep_due = r_armed && (r_tmr == TW'(P_EFF - 1));
  end else begin : g_norep
    assign w_rep_due = 1'b0;
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = r_busy;

endmodule
